// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and boot/run/trap/halt sequencing for the
// single-cycle core. pc_next and inst_valid are combinational; state, epc,
// cause and the retired-instruction count are registered here, while the PC
// register itself lives outside and captures pc_next on the same edge.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        eret,
  input  logic        trap,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        inst_valid,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [1:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    TRAP = 2'b10,
    HALT = 2'b11
  } state_t;

  // One spare bit so the counter can step past BOOT_CYCLES-1 without aliasing.
  localparam int CW = $clog2(BOOT_CYCLES) + 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  state_t        st, st_nxt;
  logic [CW-1:0] boot_cnt;
  logic [31:0]   target;
  logic          redirect;
  logic          retire;
  logic          trap_take;
  logic [1:0]    trap_code;

  assign state = st;

  // Next-PC, validity and next-state selection for the current cycle.
  always_comb begin
    pc_next    = pc_cur;
    inst_valid = 1'b0;
    st_nxt     = st;
    retire     = 1'b0;
    trap_take  = 1'b0;
    trap_code  = 2'b00;
    redirect   = eret | jump | branch_taken;
    // eret outranks jump, which outranks a taken branch.
    target     = eret ? epc : (jump ? jump_target : branch_target);
    case (st)
      BOOT: begin
        pc_next = RESET_VECTOR;
        if (boot_cnt == BOOT_LAST) st_nxt = RUN;
      end
      RUN: begin
        inst_valid = 1'b1;
        if (trap) begin
          trap_take = 1'b1;
          trap_code = 2'b01;
        end else if (stall) begin
          pc_next = pc_cur;
        end else if (redirect) begin
          // A misaligned redirect becomes a trap instead of a fetch.
          if (target[1:0] != 2'b00) begin
            trap_take = 1'b1;
            trap_code = 2'b10;
          end else begin
            pc_next = target;
            retire  = 1'b1;
          end
        end else begin
          pc_next = pc_cur + 32'd4;
          retire  = 1'b1;
          if (halt) st_nxt = HALT;
        end
      end
      TRAP: st_nxt = RUN;
      HALT: begin
        if (trap) begin
          trap_take = 1'b1;
          trap_code = 2'b01;
        end else if (resume) begin
          st_nxt = RUN;
        end
      end
      default: st_nxt = BOOT;
    endcase
    if (trap_take) begin
      pc_next = TRAP_VECTOR;
      st_nxt  = TRAP;
    end
  end

  // State, boot counter, trap bookkeeping and retire counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st       <= BOOT;
      boot_cnt <= '0;
      epc      <= '0;
      cause    <= 2'b00;
      retired  <= '0;
    end else begin
      st <= st_nxt;
      if (st == BOOT) boot_cnt <= boot_cnt + 1'b1;
      if (trap_take) begin
        epc   <= pc_cur;
        cause <= trap_code;
      end
      if (retire) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: the bench owns the PC register (fed by pc_next) and
// keeps a behavioural model of the sequencing rules, checked every cycle,
// with directed scenarios followed by a randomized run.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;
  localparam int          BC = 2;

  logic        clk, clr;
  logic [31:0] pc_reg;
  logic        stall, branch_taken, jump, eret, trap, halt, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_next, epc, retired;
  logic        inst_valid;
  logic [1:0]  cause, state;
  logic        pc_load;
  logic [31:0] pc_load_val;

  int checks = 0;
  int errors = 0;

  // Model: state as integer 0=BOOT 1=RUN 2=TRAP 3=HALT.
  int          m_state, m_boot_left;
  logic [31:0] m_epc, m_ret;
  logic [1:0]  m_cause;
  int          n_state, n_boot_left;
  logic [31:0] n_epc, n_ret;
  logic [1:0]  n_cause;
  logic [31:0] e_pc;
  logic        e_iv;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .clr(clr), .pc_cur(pc_reg), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .eret(eret), .trap(trap),
    .halt(halt), .resume(resume), .pc_next(pc_next), .inst_valid(inst_valid),
    .epc(epc), .cause(cause), .state(state), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register: captures pc_next, or a bench preload value.
  always @(posedge clk) pc_reg <= pc_load ? pc_load_val : pc_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_boot_left = BC; m_epc = '0; m_cause = 2'b00; m_ret = '0;
  endtask

  task automatic set_in(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic e,
                        input logic t, input logic h, input logic r);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    eret = e; trap = t; halt = h; resume = r;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Spec-level behaviour for one cycle from the current model state and inputs.
  task automatic model_eval();
    logic [31:0] tgt;
    e_iv = 1'b0; e_pc = pc_reg;
    n_state = m_state; n_boot_left = m_boot_left;
    n_epc = m_epc; n_cause = m_cause; n_ret = m_ret;
    if (m_state == 0) begin
      e_pc = RV;
      n_boot_left = m_boot_left - 1;
      if (m_boot_left == 1) n_state = 1;
    end else if (m_state == 1) begin
      e_iv = 1'b1;
      if (trap) begin
        e_pc = TV; n_epc = pc_reg; n_cause = 2'b01; n_state = 2;
      end else if (stall) begin
        e_pc = pc_reg;
      end else if (eret || jump || branch_taken) begin
        if (eret) tgt = m_epc;
        else if (jump) tgt = jump_target;
        else tgt = branch_target;
        if (tgt % 4 != 0) begin
          e_pc = TV; n_epc = pc_reg; n_cause = 2'b10; n_state = 2;
        end else begin
          e_pc = tgt; n_ret = m_ret + 1;
        end
      end else begin
        e_pc = pc_reg + 4; n_ret = m_ret + 1;
        if (halt) n_state = 3;
      end
    end else if (m_state == 2) begin
      n_state = 1;
    end else begin
      if (trap) begin
        e_pc = TV; n_epc = pc_reg; n_cause = 2'b01; n_state = 2;
      end else if (resume) begin
        n_state = 1;
      end
    end
  endtask

  // One cycle: inputs were set at the negedge; check, then cross the posedge.
  task automatic step();
    #1;
    model_eval();
    chk("pc_next", pc_next, e_pc);
    chk("inst_valid", 32'(inst_valid), 32'(e_iv));
    chk("state", 32'(state), 32'(m_state));
    chk("epc", epc, m_epc);
    chk("cause", 32'(cause), 32'(m_cause));
    chk("retired", retired, m_ret);
    @(posedge clk);
    m_state = n_state; m_boot_left = n_boot_left;
    m_epc = n_epc; m_cause = n_cause; m_ret = n_ret;
    @(negedge clk);
  endtask

  task automatic do_jump(input logic [31:0] t);
    set_in(0, 0, 0, 1, t, 0, 0, 0, 0); step();
  endtask

  logic [31:0] r0;

  initial begin
    clr = 1'b1; pc_load = 1'b0; pc_load_val = '0;
    idle(); model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc_next", pc_next, RV);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_iv", 32'(inst_valid), 32'd0);
    clr = 1'b0;

    // Boot then three sequential RUN cycles.
    for (int i = 0; i < 5; i++) step();
    chk("retired_after_3", retired, 32'd3);
    chk("pc_seq", pc_reg, 32'h0C);
    step();
    chk("pc_at_10", pc_reg, 32'h10);

    // Jump beats branch, then a 3-cycle stall.
    set_in(0, 1, 32'h80, 1, 32'h40, 0, 0, 0, 0); step();
    chk("jump_beats_branch", pc_reg, 32'h40);
    idle(); step();
    r0 = retired;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_pc", pc_reg, 32'h44);
    chk("stall_retired", retired, r0);

    // Trap at 0x20, bubble ignoring another trap, then eret.
    do_jump(32'h20);
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    chk("trap_pc", pc_reg, TV);
    chk("trap_epc", epc, 32'h20);
    chk("trap_cause", 32'(cause), 32'd1);
    chk("trap_state", 32'(state), 32'd2);
    step();
    chk("bubble_done", 32'(state), 32'd1);
    chk("bubble_pc", pc_reg, TV);
    idle(); step();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    chk("eret_pc", pc_reg, 32'h20);

    // Misaligned jump target traps without retiring.
    do_jump(32'h08);
    r0 = retired;
    do_jump(32'h42);
    chk("mis_cause", 32'(cause), 32'd2);
    chk("mis_epc", epc, 32'h08);
    chk("mis_pc", pc_reg, TV);
    chk("mis_retired", retired, r0);
    idle(); step();

    // Halt, idle in HALT, resume; then trap out of HALT.
    do_jump(32'h30);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    chk("halt_pc", pc_reg, 32'h34);
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("halt_state", 32'(state), 32'd3);
    chk("halt_iv", 32'(inst_valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_pc", pc_reg, 32'h34);
    do_jump(32'h30);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1); step();
    chk("halt_trap_epc", epc, 32'h34);
    chk("halt_trap_pc", pc_reg, TV);
    idle(); step();

    // PC+4 wraps at 2^32.
    pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC; step();
    pc_load = 1'b0; step();
    chk("wrap_pc", pc_reg, 32'h0);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom(); jt = $urandom();
      if ($urandom_range(7) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(7) != 0) jt[1:0] = 2'b00;
      set_in($urandom_range(4) == 0, $urandom_range(5) == 0, bt,
             $urandom_range(7) == 0, jt, $urandom_range(9) == 0,
             $urandom_range(15) == 0, $urandom_range(19) == 0,
             $urandom_range(3) == 0);
      step();
    end

    // clr asserted mid-stall resets immediately.
    idle(); step();
    stall = 1'b1; step(); step();
    #2 clr = 1'b1;
    #1;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_pc_next", pc_next, RV);
    chk("clr_iv", 32'(inst_valid), 32'd0);
    chk("clr_retired", retired, 32'd0);
    chk("clr_epc", epc, 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b0; idle();
    for (int i = 0; i < 4; i++) step();
    chk("reboot_pc", pc_reg, 32'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
